// File: rtl/uart_transmitter.sv
// UART transmit engine: 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// A one-cycle send strobe in IDLE loads a byte; done pulses for one cycle when the
// frame ends. All outputs come straight from registers.
module uart_transmitter #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic [7:0] data,
  output logic       TxD,
  output logic       ready,
  output logic       done
);

  localparam int unsigned     CntW     = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] BaudLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic            StopLast = 1'(STOP_BITS - 1);
  localparam logic            ParEn    = (PARITY_EN != 0);
  localparam logic            ParOdd   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            parity_q, parity_d;
  logic            stop_q, stop_d;
  logic            tx_q, tx_d;
  logic            ready_q, ready_d;
  logic            done_q, done_d;
  logic            boundary;

  assign boundary = (baud_q == BaudLast);
  assign TxD      = tx_q;
  assign ready    = ready_q;
  assign done     = done_q;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      baud_q   <= '0;
      bit_q    <= 3'd7;
      shift_q  <= 8'h00;
      parity_q <= 1'b0;
      stop_q   <= 1'b0;
      tx_q     <= 1'b1;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      stop_q   <= stop_d;
      tx_q     <= tx_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic; tx_d is the line level for the cycle after the edge, so TxD
  // only moves on bit boundaries (or on accept).
  always_comb begin
    state_d  = state_q;
    baud_d   = boundary ? '0 : baud_q + 1'b1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    stop_d   = stop_q;
    tx_d     = tx_q;
    ready_d  = ready_q;
    done_d   = 1'b0;

    case (state_q)
      StIdle: begin
        baud_d  = '0;
        tx_d    = 1'b1;
        ready_d = 1'b1;
        if (send) begin
          shift_d  = data;
          // Parity taken from the byte at accept, never from the shifting copy.
          parity_d = (^data) ^ ParOdd;
          state_d  = StStart;
          tx_d     = 1'b0;
          ready_d  = 1'b0;
        end
      end
      StStart: begin
        if (boundary) begin
          state_d = StData;
          bit_d   = 3'd7;
          tx_d    = shift_q[0];
        end
      end
      StData: begin
        if (boundary) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd0) begin
            if (ParEn) begin
              state_d = StParity;
              tx_d    = parity_q;
            end else begin
              state_d = StStop;
              stop_d  = 1'b0;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q - 1'b1;
            tx_d  = shift_q[1];
          end
        end
      end
      StParity: begin
        if (boundary) begin
          state_d = StStop;
          stop_d  = 1'b0;
          tx_d    = 1'b1;
        end
      end
      StStop: begin
        if (boundary) begin
          if (stop_q == StopLast) begin
            state_d = StIdle;
            done_d  = 1'b1;
            ready_d = 1'b1;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
        ready_d = 1'b1;
      end
    endcase
  end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
UART transmit engine, 8 data bits, LSB first, optional even/odd parity, 1 or 2 stop bits. It is the counterpart of the UART receiver datapath and drives the serial line back to the host. It has an internal baud-rate counter, a control FSM, a bit counter and a shift register. A one-cycle send strobe loads a byte, and done pulses when the frame completes.

Parameters:
CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200); legal values >= 2.
PARITY_EN, 0, 1 inserts a parity bit after the data bits.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored if PARITY_EN = 0.
STOP_BITS, 1, number of stop bits; legal values are 1 or 2.

Ports:
clk  input  1  system clock, all logic on its rising edge
rst  input  1  reset, synchronous, active-low (rst = 0 resets on the next clk edge)
send  input  1  transmit request, sampled every clock
data  input  8  byte to transmit, sampled only when send is accepted
TxD  output  1  serial line, idle high
ready  output  1  high when a new send will be accepted
done  output  1  one-cycle pulse at end of frame

Behaviour:
- Reset (rst = 0 at a clk edge):
  - State goes to IDLE. TxD = 1, ready = 1, done = 0.
  - Baud counter = 0, bit counter = 7, shift register = 0.
  - Reset mid-frame aborts the frame immediately. TxD returns high on that edge and no done pulse is generated.
- States: IDLE, START, DATA, PARITY, STOP.
- Bit timing: each state holds TxD for exactly CLKS_PER_BIT cycles.
  - The baud counter counts 0..CLKS_PER_BIT-1 and restarts at 0 on every state change.
  - Bit boundary = baud counter reaching CLKS_PER_BIT-1.
- IDLE:
  - TxD = 1, ready = 1.
  - send = 1 is accepted: data is latched into the shift register and the state goes to START on the same edge.
  - From the next cycle ready = 0 and TxD = 0.
  - send with ready = 0 is ignored; no queuing.
- START: TxD = 0. At the bit boundary go to DATA and load the bit counter with 7.
- DATA:
  - TxD = shift_reg[0].
  - At each bit boundary shift right by one and decrement the bit counter.
  - Leaving DATA: when the bit counter = 0 at a boundary, go to PARITY if PARITY_EN, else STOP.
- Parity value:
  - Computed from the latched byte: XOR of the 8 bits, inverted if PARITY_ODD.
  - A parity register latched at accept is acceptable; the value must not depend on shifted contents.
- PARITY: TxD = parity bit. At the boundary go to STOP.
- STOP:
  - TxD = 1 for STOP_BITS*CLKS_PER_BIT cycles.
  - At the final boundary go to IDLE, assert done for exactly that one cycle, and set ready = 1 in the following cycle.
- Frame length from accept edge to the done edge: (1 + 8 + PARITY_EN + STOP_BITS)*CLKS_PER_BIT cycles. TxD changes only on bit boundaries.
- Back-to-back frames:
  - send held high continuously starts a new frame on the first IDLE cycle.
  - Gap between the last stop bit and the next start bit is exactly one idle cycle (TxD = 1).
- data changes while busy have no effect on the frame in flight.
- All outputs are registered; no combinational path from send or data to TxD.

Test Plan:
- Reset: hold rst = 0 for 3 clks with send = 1 -> TxD = 1, ready = 1, done = 0 throughout; no frame after release until send is re-sampled.
- Single byte, CLKS_PER_BIT = 4, defaults, send 0xA5 -> TxD bits 0,1,0,1,0,0,1,0,1,1 with each bit 4 clks wide; done pulses once at cycle 40 after accept; ready returns high the next cycle.
- Parity, PARITY_EN = 1, even, send 0x07 -> parity bit 1; with PARITY_ODD = 1 -> parity bit 0; frame 44 clks at CLKS_PER_BIT = 4.
- Two stop bits, STOP_BITS = 2, send 0x00 -> start plus 8 zeros, then 8 clks high before done; total 44 clks.
- Busy and back-to-back: send 0x3C, pulse send with 0xFF mid-frame -> ignored, 0x3C sent intact. Then hold send = 1 with 0x81 -> second frame starts after exactly one idle cycle.
- Reset mid-frame: rst = 0 during DATA bit 3 of 0x55 -> TxD = 1 on the next edge, no done; after release, send 0x12 -> clean full frame.
